// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bit-slot quarter indices and R/W codes.
// Imported by the master today and intended for the existing slave as well.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    MACK,
    STOP
  } i2c_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  // SCL is low for the first half of every bit slot and high for the second.
  function automatic logic scl_high(input logic [1:0] quarter);
    return quarter[1];
  endfunction

endpackage

// File: rtl/i2c_master_if.sv
// Host-side request/response bundle of the I2C master, plus the FSM state for observation.
// Handshake: the host pulses i_start for one cycle while o_busy=0; the request is taken
// on that edge, o_busy stays high until the edge that raises the single-cycle o_done.
interface i2c_master_if #(
  parameter int Data_width = 8,
  parameter int Address    = 7
);
  import i2c_pkg::*;

  logic                  i_start;
  logic                  i_rw;
  logic [Address-1:0]    i_addr;
  logic [Data_width-1:0] i_data;
  logic [Data_width-1:0] o_data;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_ack_err;
  i2c_state_e            state;

  modport master (
    output i_start, i_rw, i_addr, i_data,
    input  o_data, o_busy, o_done, o_ack_err, state
  );

  modport slave (
    input  i_start, i_rw, i_addr, i_data,
    output o_data, o_busy, o_done, o_ack_err, state
  );

endinterface

// File: rtl/i2c_clk_div.sv
// Quarter-period timebase: a DIV-cycle counter whose wrap advances a 2-bit quarter index.
// Held at zero while clr is high so every transaction starts on a fresh Q0.
module i2c_clk_div
  import i2c_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    quarter_q, quarter_d;

  assign tick    = (cnt_q == CW'(DIV - 1));
  assign quarter = quarter_q;

  always_comb begin
    cnt_d     = cnt_q;
    quarter_d = quarter_q;
    if (clr) begin
      cnt_d     = '0;
      quarter_d = Q0;
    end else if (tick) begin
      cnt_d     = '0;
      quarter_d = quarter_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      quarter_q <= Q0;
    end else begin
      cnt_q     <= cnt_d;
      quarter_q <= quarter_d;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C initiator: one START/addr/ACK/byte/ACK/STOP transaction per request.
// SCL is push-pull from the quarter timebase; SDA is open-drain (drives 0 or releases).
module i2c_master
  import i2c_pkg::*;
#(
  parameter int Data_width = 8,
  parameter int Address    = 7,
  parameter int DIV        = 4
) (
  input  logic         clk,
  input  logic         rst,
  i2c_master_if.slave  host,
  inout  wire          i2c_sda,
  output logic         i2c_sclk
);

  i2c_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [Address:0]      sh_addr_q, sh_addr_d;
  logic [Data_width-1:0] sh_data_q, sh_data_d;
  logic [Data_width-1:0] data_q, data_d;
  logic                  rw_q, rw_d;
  logic                  ack_err_q, ack_err_d;
  logic                  ack_smp_q, ack_smp_d;
  logic                  done_q, done_d;
  logic [1:0]            sda_sync_q, sda_sync_d;

  logic       tick;
  logic [1:0] quarter;
  logic       sample, slot_end, accept, sda_in;
  logic       scl, sda_oe;

  i2c_clk_div #(.DIV(DIV)) u_clk_div (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == IDLE),
    .tick    (tick),
    .quarter (quarter)
  );

  // Sample on the last clk of Q2 (mid SCL-high); the slot ends on the last clk of Q3.
  assign sample     = tick && (quarter == Q2);
  assign slot_end   = tick && (quarter == Q3);
  assign accept     = host.i_start && (state_q == IDLE) && !done_q;
  assign sda_in     = sda_sync_q[1];
  assign sda_sync_d = {sda_sync_q[0], i2c_sda};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_addr_d = sh_addr_q;
    sh_data_d = sh_data_q;
    data_d    = data_q;
    rw_d      = rw_q;
    ack_err_d = ack_err_q;
    ack_smp_d = ack_smp_q;
    done_d    = 1'b0;
    scl       = 1'b1;
    sda_oe    = 1'b0;
    if (sample) ack_smp_d = sda_in;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          sh_addr_d = {host.i_addr, host.i_rw};
          sh_data_d = host.i_data;
          rw_d      = host.i_rw;
          ack_err_d = 1'b0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        sda_oe = scl_high(quarter);
        if (slot_end) state_d = ADDR;
      end
      ADDR: begin
        scl    = scl_high(quarter);
        sda_oe = !sh_addr_q[Address];
        if (slot_end) begin
          sh_addr_d = {sh_addr_q[Address-1:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ADDR_ACK;
        end
      end
      ADDR_ACK: begin
        scl = scl_high(quarter);
        if (slot_end) begin
          if (ack_smp_q) begin
            ack_err_d = 1'b1;
            state_d   = STOP;
          end else if (rw_q == I2C_RW_READ) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        scl    = scl_high(quarter);
        sda_oe = !sh_data_q[Data_width-1];
        if (slot_end) begin
          sh_data_d = {sh_data_q[Data_width-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = WRITE_ACK;
        end
      end
      WRITE_ACK: begin
        scl = scl_high(quarter);
        if (slot_end) begin
          if (ack_smp_q) ack_err_d = 1'b1;
          state_d = STOP;
        end
      end
      READ: begin
        scl = scl_high(quarter);
        if (sample) data_d = {data_q[Data_width-2:0], sda_in};
        if (slot_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = MACK;
        end
      end
      MACK: begin
        // Released SDA is the NACK that ends a single-byte read.
        scl = scl_high(quarter);
        if (slot_end) state_d = STOP;
      end
      STOP: begin
        scl    = scl_high(quarter);
        sda_oe = (quarter != Q3);
        if (slot_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sh_addr_q  <= '0;
      sh_data_q  <= '0;
      data_q     <= '0;
      rw_q       <= I2C_RW_WRITE;
      ack_err_q  <= 1'b0;
      ack_smp_q  <= 1'b1;
      done_q     <= 1'b0;
      sda_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_addr_q  <= sh_addr_d;
      sh_data_q  <= sh_data_d;
      data_q     <= data_d;
      rw_q       <= rw_d;
      ack_err_q  <= ack_err_d;
      ack_smp_q  <= ack_smp_d;
      done_q     <= done_d;
      sda_sync_q <= sda_sync_d;
    end
  end

  assign i2c_sda        = sda_oe ? 1'b0 : 1'bz;
  assign i2c_sclk       = scl;
  assign host.o_data    = data_q;
  assign host.o_busy    = (state_q != IDLE);
  assign host.o_done    = done_q;
  assign host.o_ack_err = ack_err_q;
  assign host.state     = state_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a behavioural I2C target on a pulled-up SDA line.
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl;
  wire  sda;
  logic tgt_low = 1'b0;

  assign sda = tgt_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_master_if #(.Data_width(8), .Address(7)) host_if ();

  i2c_master #(.Data_width(8), .Address(7), .DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .host     (host_if.slave),
    .i2c_sda  (sda),
    .i2c_sclk (scl)
  );

  always #5 clk = ~clk;

  // ---------------- target model ----------------
  logic       tgt_read     = 1'b0;
  logic       tgt_ack_addr = 1'b1;
  logic       tgt_ack_data = 1'b1;
  logic [7:0] tgt_rd_byte  = 8'h00;
  int         slot         = 0;
  int         stop_cnt     = 0;
  logic       cap [0:19];
  logic       scl_p        = 1'b1;
  logic       sda_p        = 1'b1;

  always @(negedge clk) begin
    if (scl && scl_p && sda_p && !sda) begin
      slot = -1;
    end else if (scl && scl_p && !sda_p && sda) begin
      stop_cnt++;
    end else if (scl && !scl_p) begin
      if (slot >= 0 && slot < 20) cap[slot] = sda;
    end else if (!scl && scl_p) begin
      slot++;
      tgt_low = 1'b0;
      if (slot == 8) tgt_low = tgt_ack_addr;
      else if (slot >= 9 && slot <= 16 && tgt_read) tgt_low = !tgt_rd_byte[3'(16 - slot)];
      else if (slot == 17 && !tgt_read) tgt_low = tgt_ack_data;
    end
    scl_p = scl;
    sda_p = sda;
  end

  // ---------------- scoreboard ----------------
  int         vec_cnt     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cap_byte(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = cap[base+i];
    return b;
  endfunction

  // Called at #1 after a posedge; returns at #1 after the edge that raised o_done.
  task automatic do_txn(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                        input int poke_at, output int cycles);
    host_if.i_rw    = rw;
    host_if.i_addr  = addr;
    host_if.i_data  = data;
    host_if.i_start = 1'b1;
    @(posedge clk); #1;
    host_if.i_start = 1'b0;
    check("busy_after_accept", 32'(host_if.o_busy), 32'd1);
    cycles = 0;
    while (cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
      host_if.i_start = 1'b0;
      if (host_if.o_done) break;
      if (cycles == poke_at) host_if.i_start = 1'b1;
    end
    if (!host_if.o_done) check("done_timeout", 32'(cycles), 32'd0);
    check("busy_low_at_done", 32'(host_if.o_busy), 32'd0);
  endtask

  task automatic check_bytes(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check({tag, "_addr_byte"}, 32'(cap_byte(0)), 32'(e));
    e = exp_q.pop_front();
    check({tag, "_data_byte"}, 32'(cap_byte(9)), 32'(e));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int stops;

    host_if.i_start = 1'b0;
    host_if.i_rw    = 1'b0;
    host_if.i_addr  = '0;
    host_if.i_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", 32'(scl), 32'd1);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_busy", 32'(host_if.o_busy), 32'd0);
    check("rst_done", 32'(host_if.o_done), 32'd0);
    check("rst_ack_err", 32'(host_if.o_ack_err), 32'd0);
    check("rst_data", 32'(host_if.o_data), 32'd0);
    check("rst_state", 32'(host_if.state), 32'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: write 0xA5 to 0x42, target ACKs
    tgt_read = 1'b0; tgt_ack_addr = 1'b1; tgt_ack_data = 1'b1;
    exp_q.push_back(8'h84); exp_q.push_back(8'hA5);
    stops = stop_cnt;
    do_txn(I2C_RW_WRITE, 7'h42, 8'hA5, -1, cyc);
    check("wr_latency", 32'(cyc), 32'd320);
    check("wr_ack_err", 32'(host_if.o_ack_err), 32'd0);
    check("wr_addr_ack_bit", 32'(cap[8]), 32'd0);
    check("wr_stop", 32'(stop_cnt), 32'(stops + 1));
    check_bytes("wr");
    @(posedge clk); #1;
    check("wr_done_one_cycle", 32'(host_if.o_done), 32'd0);

    // 2: read from 0x42, target returns 0x3C
    tgt_read = 1'b1; tgt_rd_byte = 8'h3C;
    stops = stop_cnt;
    do_txn(I2C_RW_READ, 7'h42, 8'h00, -1, cyc);
    check("rd_latency", 32'(cyc), 32'd320);
    check("rd_data", 32'(host_if.o_data), 32'h3C);
    check("rd_addr_byte", 32'(cap_byte(0)), 32'h85);
    check("rd_master_nack", 32'(cap[17]), 32'd1);
    check("rd_stop", 32'(stop_cnt), 32'(stops + 1));
    check("rd_ack_err", 32'(host_if.o_ack_err), 32'd0);
    @(posedge clk); #1;

    // 3: address NACK, nobody answers 0x11
    tgt_read = 1'b0; tgt_ack_addr = 1'b0;
    stops = stop_cnt;
    do_txn(I2C_RW_WRITE, 7'h11, 8'h5A, -1, cyc);
    check("anack_latency", 32'(cyc), 32'd176);
    check("anack_ack_err", 32'(host_if.o_ack_err), 32'd1);
    check("anack_slots", 32'(slot), 32'd9);
    check("anack_stop", 32'(stop_cnt), 32'(stops + 1));
    check("anack_addr_byte", 32'(cap_byte(0)), 32'h22);
    @(posedge clk); #1;

    // 4: data NACK
    tgt_ack_addr = 1'b1; tgt_ack_data = 1'b0;
    exp_q.push_back(8'h84); exp_q.push_back(8'h0F);
    do_txn(I2C_RW_WRITE, 7'h42, 8'h0F, -1, cyc);
    check("dnack_latency", 32'(cyc), 32'd320);
    check("dnack_ack_err", 32'(host_if.o_ack_err), 32'd1);
    check_bytes("dnack");
    @(posedge clk); #1;
    check("dnack_ack_err_held", 32'(host_if.o_ack_err), 32'd1);

    // 5: starts while busy and coincident with o_done are dropped
    tgt_ack_data = 1'b1;
    exp_q.push_back(8'hB4); exp_q.push_back(8'h5A);
    do_txn(I2C_RW_WRITE, 7'h5A, 8'h5A, 50, cyc);
    check("busy_start_latency", 32'(cyc), 32'd320);
    check("busy_start_ack_err", 32'(host_if.o_ack_err), 32'd0);
    check_bytes("busy_start");
    host_if.i_start = 1'b1;
    @(posedge clk); #1;
    host_if.i_start = 1'b0;
    check("done_start_ignored", 32'(host_if.o_busy), 32'd0);
    exp_q.push_back(8'h84); exp_q.push_back(8'hC3);
    do_txn(I2C_RW_WRITE, 7'h42, 8'hC3, -1, cyc);
    check("next_start_latency", 32'(cyc), 32'd320);
    check_bytes("next_start");
    @(posedge clk); #1;

    // 6: reset during address bit 3
    host_if.i_rw = I2C_RW_WRITE; host_if.i_addr = 7'h42; host_if.i_data = 8'hA5;
    host_if.i_start = 1'b1;
    @(posedge clk); #1;
    host_if.i_start = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    check("pre_rst_state", 32'(host_if.state), 32'(ADDR));
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_sclk", 32'(scl), 32'd1);
    check("midrst_sda", 32'(sda), 32'd1);
    check("midrst_busy", 32'(host_if.o_busy), 32'd0);
    check("midrst_done", 32'(host_if.o_done), 32'd0);
    check("midrst_state", 32'(host_if.state), 32'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(8'h84); exp_q.push_back(8'hA5);
    do_txn(I2C_RW_WRITE, 7'h42, 8'hA5, -1, cyc);
    check("post_rst_latency", 32'(cyc), 32'd320);
    check("post_rst_ack_err", 32'(host_if.o_ack_err), 32'd0);
    check_bytes("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-master I2C initiator that runs one complete single-byte transaction per request.
- Sequence: START, 7-bit address + R/W, address ACK, one data byte (write to or read from the target), ACK/NACK, STOP.
- Generates SCL from the system clock by a quarter-period divider and drives SDA open-drain.
- Sits opposite the existing I2C slave on the same two-wire bus; the host side is a simple start/done handshake.

Parameters:
- Data_width, 8, data byte width (only 8 is supported).
- Address, 7, target address width.
- DIV, 4, system clocks per SCL quarter-period (minimum 2). SCL period = 4*DIV clk.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle request; accepted only while o_busy=0.
- i_rw  input  1  0 = write byte to target, 1 = read byte from target.
- i_addr  input  Address  7-bit target address.
- i_data  input  Data_width  byte to write.
- o_data  output  Data_width  byte read; valid when o_done=1 for a read.
- o_busy  output  1  high from the cycle after i_start is accepted until the cycle o_done pulses.
- o_done  output  1  one-cycle pulse at end of STOP.
- o_ack_err  output  1  set if the address or write-data ACK was NACK; valid with o_done, held until next accept.
- i2c_sda  inout  1  driven 0 or Z only, never driven 1.
- i2c_sclk  output  1  push-pull SCL (single master).

Behaviour:
- Reset values: i2c_sclk=1, SDA released (Z), o_data=0, o_busy=0, o_done=0, o_ack_err=0, state IDLE, counters 0.
- rst asserted mid-transfer returns to IDLE next cycle with the bus released. No STOP is generated.

Capture and timing:
- On accept, latch {i_addr, i_rw} into shift register sh_addr and i_data into sh_data. Clear o_ack_err.
- Quarter tick = DIV-cycle counter wrap. Every bit slot is 4 quarters:
  - Q0: SCL low; SDA updated at the start of Q0.
  - Q1: SCL low.
  - Q2: SCL high.
  - Q3: SCL high.
- SDA is sampled on the last clk of Q2, which is mid SCL-high.

States:
- IDLE: SCL=1, SDA=Z. i_start goes to START.
- START (4 quarters): Q0–Q1 SDA=Z, SCL=1; Q2–Q3 SDA=0, SCL=1. Then go to ADDR.
- ADDR: 8 bit slots, MSB first: addr[6]..addr[0], then R/W. Bit=1 releases SDA; bit=0 drives 0.
- ADDR_ACK: SDA=Z, sample the bit.
  - 1 (NACK): set o_ack_err, go to STOP.
  - 0 and rw=0: go to WRITE.
  - 0 and rw=1: go to READ.
- WRITE: 8 slots MSB first from sh_data. Then WRITE_ACK: SDA=Z, sample; 1 sets o_ack_err. Then STOP.
- READ: 8 slots, SDA=Z, shift the sampled bit into o_data LSB-side (MSB received first). Then MACK: master sends NACK (SDA=Z) to end the single-byte read. Then STOP.
- STOP (4 quarters): Q0–Q1 SCL=0, SDA=0; Q2 SCL=1, SDA=0; Q3 SCL=1, SDA=Z. At the end, pulse o_done, drop o_busy, go to IDLE.

Latency:
- Full transaction = 4 + 36 + 36 + 4 = 80 quarters = 80*DIV clk from accept to o_done. This is 320 clk at DIV=4.
- Address NACK skips the data phase: 44 quarters = 44*DIV clk.

Boundary conditions:
- i_start while busy is ignored, with no queueing.
- i_start in the same cycle as o_done is ignored; accept is possible from the next cycle.
- SCL stretching is not supported; SCL is never sampled.
- The bit counter is 3 bits and wraps 7→0 at byte end.

Decomposition:
- Package i2c_pkg holds:
  - state encoding constants (IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, MACK, STOP);
  - quarter indices Q0..Q3;
  - I2C_RW_WRITE = 0, I2C_RW_READ = 1.
- The existing slave should adopt the same package.
- Sub-module i2c_clk_div: DIV counter producing the quarter tick and 2-bit quarter index. Restarted on accept, held in IDLE.
- The FSM, shift registers and SDA/SCL drivers stay in i2c_master.

Test Plan:
1. Write, addr 0x42, data 0xA5, target model ACKs:
   - SDA shows 0x84 then 0xA5 MSB-first on SCL rising edges.
   - o_done exactly 320 clk after accept; o_ack_err=0.
2. Read, addr 0x42, target model drives 0x3C:
   - o_data=0x3C at o_done.
   - SDA released (NACK=1) in bit slot 18.
   - Valid STOP: SDA rises while SCL high.
3. Address NACK, write to 0x11 with no target responding:
   - o_ack_err=1.
   - No data slots; STOP follows the ACK slot.
   - o_done at 176 clk.
4. Write-data NACK, target ACKs address but NACKs data:
   - o_ack_err=1, o_done at 320 clk.
5. i_start pulsed at cycle 50 of a transfer, and again coincident with o_done:
   - Both are ignored; no second transaction.
   - A request one cycle after o_done is accepted.
6. rst held for 1 cycle during ADDR bit 3:
   - Next cycle: i2c_sclk=1, SDA=Z, o_busy=0, o_done=0.
   - A new request then completes normally.
